// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: register offsets,
// field positions, blank pattern and digit/nibble mask helpers.
package seg7_pkg;

  localparam logic [2:0] SEG7_ADDR_DATA_LO = 3'd0;
  localparam logic [2:0] SEG7_ADDR_DATA_HI = 3'd2;
  localparam logic [2:0] SEG7_ADDR_CTRL    = 3'd4;
  localparam logic [2:0] SEG7_ADDR_BLINK   = 3'd6;

  localparam int unsigned SEG7_CTRL_EN_LSB     = 8;
  localparam int unsigned SEG7_CTRL_DP_LSB     = 0;
  localparam int unsigned SEG7_BLINK_MASK_LSB  = 0;
  localparam int unsigned SEG7_BLINK_BLANK_BIT = 15;

  localparam logic [7:0] SEG7_BLANK = 8'hFF;

  // One bit per present digit; absent digits are forced to 0.
  function automatic logic [7:0] seg7_digit_mask(input int unsigned num_digits);
    logic [7:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (i < num_digits) m[i] = 1'b1;
    return m;
  endfunction

  // One nibble per present digit across {DATA_HI, DATA_LO}.
  function automatic logic [31:0] seg7_nibble_mask(input int unsigned num_digits);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (i < num_digits) m[i*4 +: 4] = 4'hF;
    return m;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit to 7-segment decoder, active low, bit 6 = CA ... bit 0 = CG.
module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    case (nibble)
      4'h0: seg_n = 7'b0000001;
      4'h1: seg_n = 7'b1001111;
      4'h2: seg_n = 7'b0010010;
      4'h3: seg_n = 7'b0000110;
      4'h4: seg_n = 7'b1001100;
      4'h5: seg_n = 7'b0100100;
      4'h6: seg_n = 7'b0100000;
      4'h7: seg_n = 7'b0001111;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0000100;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b1100000;
      4'hC: seg_n = 7'b0110001;
      4'hD: seg_n = 7'b1000010;
      4'hE: seg_n = 7'b0110000;
      4'hF: seg_n = 7'b0111000;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 7-segment scan controller: register file with readback,
// slot/digit/frame counters with blink phase, and a registered output stage.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 25000,
  parameter int unsigned DEAD_CYCLES  = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [2:0]  address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic [7:0]  enable_n,
  output logic [7:0]  seg_n
);

  localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [7:0]         DIGIT_MASK  = seg7_digit_mask(NUM_DIGITS);
  localparam logic [31:0]        NIBBLE_MASK = seg7_nibble_mask(NUM_DIGITS);
  localparam logic [SLOT_W-1:0]  SLOT_LAST   = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  SLOT_DEAD   = SLOT_W'(DEAD_CYCLES);
  localparam logic [2:0]         IDX_LAST    = 3'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(BLINK_FRAMES - 1);

  logic [15:0] data_lo, data_hi;
  logic [7:0]  digit_en, dp_mask, blink_mask;
  logic        blank;

  logic [SLOT_W-1:0]  slot_cnt;
  logic [2:0]         idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               phase;

  logic        wr, rd;
  logic [15:0] rd_value;
  logic        slot_wrap, idx_wrap;
  logic [31:0] data_all;
  logic [3:0]  cur_nibble;
  logic [6:0]  cur_seg_n;
  logic        lit;

  assign wr = cs & write_enable;
  assign rd = cs & read_enable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_lo    <= '0;
      data_hi    <= '0;
      digit_en   <= '0;
      dp_mask    <= '0;
      blink_mask <= '0;
      blank      <= 1'b0;
    end else if (wr) begin
      case (address)
        SEG7_ADDR_DATA_LO: data_lo <= write_data & NIBBLE_MASK[15:0];
        SEG7_ADDR_DATA_HI: data_hi <= write_data & NIBBLE_MASK[31:16];
        SEG7_ADDR_CTRL: begin
          digit_en <= write_data[SEG7_CTRL_EN_LSB +: 8] & DIGIT_MASK;
          dp_mask  <= write_data[SEG7_CTRL_DP_LSB +: 8] & DIGIT_MASK;
        end
        SEG7_ADDR_BLINK: begin
          blink_mask <= write_data[SEG7_BLINK_MASK_LSB +: 8] & DIGIT_MASK;
          blank      <= write_data[SEG7_BLINK_BLANK_BIT];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_value = '0;
    case (address)
      SEG7_ADDR_DATA_LO: rd_value = data_lo;
      SEG7_ADDR_DATA_HI: rd_value = data_hi;
      SEG7_ADDR_CTRL:    rd_value = {digit_en, dp_mask};
      SEG7_ADDR_BLINK:   rd_value = {blank, 7'b0, blink_mask};
      default:           rd_value = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   read_data <= '0;
    else if (rd) read_data <= rd_value;
  end

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign idx_wrap  = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      if (slot_wrap)
        idx <= (idx == IDX_LAST) ? '0 : idx + 3'd1;
      if (idx_wrap) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  assign data_all   = {data_hi, data_lo};
  assign cur_nibble = data_all[{idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg_n  (cur_seg_n)
  );

  assign lit = !blank && digit_en[idx] && !(blink_mask[idx] && phase)
               && (slot_cnt >= SLOT_DEAD);

  // Single register stage for anodes and segments so both switch together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_n <= SEG7_BLANK;
      seg_n    <= SEG7_BLANK;
    end else if (lit) begin
      enable_n <= ~(8'b1 << idx);
      seg_n    <= {cur_seg_n, ~dp_mask[idx]};
    end else begin
      enable_n <= SEG7_BLANK;
      seg_n    <= SEG7_BLANK;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with a 4-cycle slot,
// 1 dead cycle and a 2-frame blink half-period.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, write_enable, read_enable;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  enable_n, seg_n;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (8),
    .SCAN_DIV     (4),
    .DEAD_CYCLES  (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cs           (cs),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .enable_n     (enable_n),
    .seg_n        (seg_n)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clock);
    cs = 1'b1; write_enable = 1'b1; address = addr; write_data = data;
    @(negedge clock);
    cs = 1'b0; write_enable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    @(negedge clock);
    cs = 1'b1; read_enable = 1'b1; address = addr;
    @(negedge clock);
    cs = 1'b0; read_enable = 1'b0;
    check(tag, {16'h0, read_data}, {16'h0, exp});
  endtask

  // Wait for the first lit cycle of digit tgt (anodes off the cycle before).
  task automatic align(input string tag, input logic [7:0] tgt);
    logic [7:0] prev;
    bit found;
    found = 1'b0;
    prev  = enable_n;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clock);
      if (prev == 8'hFF && enable_n == tgt) found = 1'b1;
      else prev = enable_n;
    end
    check(tag, {31'h0, found}, 32'h1);
  endtask

  initial begin
    int q, p, d;
    logic [7:0] exp_e, exp_s;
    int c0 [4];
    int c1 [4];
    int c2 [4];

    reset = 1'b1; cs = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    address = '0; write_data = '0;
    repeat (3) @(negedge clock);
    check("reset_out", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    check("reset_rd", {16'h0, read_data}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("idle_out", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    end
    read_check("idle_ctrl", SEG7_ADDR_CTRL, 16'h0000);

    // All digits enabled, each shows its own index.
    write_reg(SEG7_ADDR_DATA_LO, 16'h3210);
    write_reg(SEG7_ADDR_DATA_HI, 16'h7654);
    write_reg(SEG7_ADDR_CTRL, 16'hFF00);
    align("align_all", 8'hFE);
    for (int c = 0; c < 32; c++) begin
      q = c + 1; p = q % 4; d = (q / 4) % 8;
      if (p == 0) begin exp_e = 8'hFF; exp_s = 8'hFF; end
      else begin exp_e = ~(8'b1 << d); exp_s = {hex7(4'(d)), 1'b1}; end
      check("scan_all", {16'h0, enable_n, seg_n}, {16'h0, exp_e, exp_s});
      @(negedge clock);
    end

    // Digits 4..7 disabled, DP on digit 0.
    write_reg(SEG7_ADDR_CTRL, 16'h0F01);
    align("align_low", 8'hFE);
    for (int c = 0; c < 32; c++) begin
      q = c + 1; p = q % 4; d = (q / 4) % 8;
      if (p == 0 || d > 3) begin exp_e = 8'hFF; exp_s = 8'hFF; end
      else begin exp_e = ~(8'b1 << d); exp_s = {hex7(4'(d)), (d == 0) ? 1'b0 : 1'b1}; end
      check("scan_low", {16'h0, enable_n, seg_n}, {16'h0, exp_e, exp_s});
      @(negedge clock);
    end
    read_check("rd_ctrl", SEG7_ADDR_CTRL, 16'h0F01);
    read_check("rd_addr3", 3'd3, 16'h0000);
    read_check("rd_data_hi", SEG7_ADDR_DATA_HI, 16'h7654);

    // Blink digits 0,1; digit 2 stays steady as the frame reference.
    write_reg(SEG7_ADDR_BLINK, 16'h0003);
    read_check("rd_blink", SEG7_ADDR_BLINK, 16'h0003);
    align("align_blink", 8'hFB);
    for (int f = 0; f < 4; f++) begin
      c0[f] = 0; c1[f] = 0; c2[f] = 0;
      for (int c = 0; c < 32; c++) begin
        if (enable_n == 8'hFE) c0[f]++;
        if (enable_n == 8'hFD) c1[f]++;
        if (enable_n == 8'hFB) c2[f]++;
        @(negedge clock);
      end
    end
    for (int f = 0; f < 4; f++) begin
      check("blink_steady", c2[f], 3);
      check("blink_pair", c1[f], c0[f]);
      check("blink_onoff", {31'h0, (c0[f] == 0 || c0[f] == 3)}, 32'h1);
    end
    check("blink_total", c0[0] + c0[1] + c0[2] + c0[3], 6);
    check("blink_period0", {31'h0, (c0[0] != c0[2])}, 32'h1);
    check("blink_period1", {31'h0, (c0[1] != c0[3])}, 32'h1);

    // Global blank.
    write_reg(SEG7_ADDR_BLINK, 16'h8000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("blank_out", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    end
    read_check("rd_blank", SEG7_ADDR_BLINK, 16'h8000);
    write_reg(SEG7_ADDR_BLINK, 16'h0000);
    write_reg(SEG7_ADDR_CTRL, 16'hFF01);

    // DATA_LO write on the edge where the index wraps 7 -> 0.
    align("align_wr", 8'hFE);
    repeat (29) @(negedge clock);
    check("adv_d7a", {16'h0, enable_n, seg_n}, {16'h0, 8'h7F, hex7(4'h7), 1'b1});
    cs = 1'b1; write_enable = 1'b1; address = SEG7_ADDR_DATA_LO; write_data = 16'h321A;
    @(negedge clock);
    cs = 1'b0; write_enable = 1'b0;
    check("adv_d7b", {16'h0, enable_n, seg_n}, {16'h0, 8'h7F, hex7(4'h7), 1'b1});
    @(negedge clock);
    check("adv_dead", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("adv_new", {16'h0, enable_n, seg_n}, {16'h0, 8'hFE, hex7(4'hA), 1'b0});
    end
    @(negedge clock);
    check("adv_dead2", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    @(negedge clock);
    check("adv_d1", {16'h0, enable_n, seg_n}, {16'h0, 8'hFD, hex7(4'h1), 1'b1});

    // Asynchronous reset while digit 1 is lit.
    #1 reset = 1'b1;
    #1 check("rst_async", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    @(negedge clock);
    reset = 1'b0;
    cs = 1'b1; write_enable = 1'b1; address = SEG7_ADDR_CTRL; write_data = 16'hFF00;
    @(negedge clock);
    cs = 1'b0; write_enable = 1'b0;
    check("rst_slot0", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_d0", {16'h0, enable_n, seg_n}, 32'h0000FE03);
    end
    @(negedge clock);
    check("rst_dead", {16'h0, enable_n, seg_n}, 32'h0000FFFF);
    @(negedge clock);
    check("rst_d1", {16'h0, enable_n, seg_n}, 32'h0000FD03);
    read_check("rst_data_lo", SEG7_ADDR_DATA_LO, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
